instruction_fetch_unit: RTL

Sequences the instruction memory for the single-cycle/pipelined core: owns the program counter, drives the byte address into the 16-byte little-endian instruction memory, captures each 32-bit word with its PC into a 2-entry prefetch buffer, and hands it to decode over a valid/ready handshake. Handles branch redirects (buffer flush), end-of-memory halt and misaligned-target faults. Sits between instruction memory and the decode stage.

---
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the instruction memory and queues
// {PC, word} pairs in a 2-entry prefetch buffer handed to decode via valid/ready.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic        Fetch_Valid,
  output logic [63:0] Fetch_PC,
  output logic [31:0] Fetch_Instruction,
  input  logic        Decode_Ready,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  output logic        Fetch_Halted,
  output logic        Fetch_Fault
);

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic [63:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic [1:0]  count;
  logic [1:0]  fill_level;
  logic        pop, push, pc_in_range, target_ok;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_next  = state;
    pc_next     = pc;
    pc_in_range = (pc <= LAST_PC);
    target_ok   = (Branch_Target[1:0] == 2'b00) && (Branch_Target <= LAST_PC);
    pop         = (count != 2'd0) && Decode_Ready && !Branch_Taken;
    push        = (state == RUN) && !Branch_Taken && pc_in_range &&
                  ((count != 2'd2) || pop);
    fill_level  = count - {1'b0, pop};

    if (Branch_Taken) begin
      if (target_ok) begin
        pc_next    = Branch_Target;
        state_next = RUN;
      end else begin
        state_next = FAULT;
      end
    end else if (push) begin
      pc_next = pc + 64'd4;
    end else if ((state == RUN) && !pc_in_range) begin
      state_next = HALT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // NOTE: the buffer is reset because entry 0 is also the held head output, which must read 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= 2'd0;
      buf_pc[0]    <= '0;
      buf_pc[1]    <= '0;
      buf_instr[0] <= '0;
      buf_instr[1] <= '0;
    end else if (Branch_Taken) begin
      count <= 2'd0;
    end else begin
      if (pop && (count == 2'd2)) begin
        buf_pc[0]    <= buf_pc[1];
        buf_instr[0] <= buf_instr[1];
      end
      if (push) begin
        buf_pc[fill_level[0]]    <= pc;
        buf_instr[fill_level[0]] <= Instruction;
        count                    <= fill_level + 2'd1;
      end else begin
        count <= fill_level;
      end
    end
  end

  // Entry 0 is left untouched when the buffer empties, so the head outputs hold their last value.
  assign Inst_Address      = pc;
  assign Fetch_Valid       = (count != 2'd0);
  assign Fetch_PC          = buf_pc[0];
  assign Fetch_Instruction = buf_instr[0];
  assign Fetch_Halted      = (state == HALT);
  assign Fetch_Fault       = (state == FAULT);

endmodule
